// File: rtl/z_pkg.sv
// Shared types and helpers for the z_accum_array engine and its lanes.
// Z_SAT_EN selects saturating (defined) or wrap-around (undefined) z reduction.
package z_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest value the reduction helper handles; lanes sign-extend into it.
    localparam int MAXW = 64;

    // Full product width plus headroom for DEPTH products and the pre-shifted bias.
    function automatic int acc_width(input int dwidth, input int depth);
        return 2 * dwidth + $clog2(depth) + 1;
    endfunction

    // Clamp v into a signed dwidth-bit range; result is {sat, clamped value}.
    function automatic logic [MAXW:0] sat_reduce(input logic signed [MAXW-1:0] v,
                                                 input int dwidth);
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        hi = (MAXW'(1) <<< (dwidth - 1)) - MAXW'(1);
        lo = -(MAXW'(1) <<< (dwidth - 1));
        if (v > hi) begin
            return {1'b1, hi};
        end else if (v < lo) begin
            return {1'b1, lo};
        end else begin
            return {1'b0, v};
        end
    endfunction

endpackage

// File: rtl/z_lane.sv
// One neuron lane: wide accumulator, multiplier, >>> FRAC and reduction to DWIDTH.
// Saturation comparators exist only when Z_SAT_EN is defined.
module z_lane
    import z_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int FRAC   = 8,
    parameter int ACCW   = 39
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              beat,
    input  logic              capture,
    input  logic [DWIDTH-1:0] bias,
    input  logic [DWIDTH-1:0] x,
    input  logic [DWIDTH-1:0] w,
    output logic [DWIDTH-1:0] z,
    output logic              sat
);

    logic signed [2*DWIDTH-1:0] prod;
    logic signed [ACCW-1:0]     prod_ext;
    logic signed [ACCW-1:0]     bias_ext;
    logic signed [ACCW-1:0]     acc;
    logic signed [ACCW-1:0]     acc_next;
    logic signed [ACCW-1:0]     shifted;
    logic        [DWIDTH-1:0]   z_next;

    assign prod     = $signed(x) * $signed(w);
    assign prod_ext = $signed({{(ACCW-2*DWIDTH){prod[2*DWIDTH-1]}}, prod});
    assign bias_ext = $signed({{(ACCW-DWIDTH){bias[DWIDTH-1]}}, bias}) <<< FRAC;

    // z is taken from the value being written, so the last beat and z line up.
    assign acc_next = load ? bias_ext : acc + prod_ext;
    assign shifted  = acc_next >>> FRAC;

`ifdef Z_SAT_EN
    logic [MAXW:0]          reduced;
    logic                   sat_next;
    logic                   unused_reduced;

    assign reduced        = sat_reduce($signed({{(MAXW-ACCW){shifted[ACCW-1]}}, shifted}), DWIDTH);
    assign z_next         = reduced[DWIDTH-1:0];
    assign sat_next       = reduced[MAXW];
    assign unused_reduced = ^reduced[MAXW-1:DWIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat <= 1'b0;
        end else if (capture) begin
            sat <= sat_next;
        end
    end
`else
    logic unused_shifted;

    assign z_next         = shifted[DWIDTH-1:0];
    assign unused_shifted = ^shifted[ACCW-1:DWIDTH];
    assign sat            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            z   <= '0;
        end else begin
            if (load || beat) begin
                acc <= acc_next;
            end
            if (capture) begin
                z <= z_next;
            end
        end
    end

endmodule

// File: rtl/z_accum_array.sv
// Multi-lane z = b + sum(x*w) engine: FSM, beat counter and handshakes around LANES z_lane copies.
// Build option: define Z_SAT_EN for saturating z outputs with per-lane sat flags.
module z_accum_array
    import z_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int FRAC   = 8,
    parameter int LANES  = 4,
    parameter int DEPTH  = 64,
    parameter int CWIDTH = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CWIDTH-1:0]       n_inputs,
    input  logic [LANES*DWIDTH-1:0] bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DWIDTH-1:0]       x_in,
    input  logic [LANES*DWIDTH-1:0] w_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DWIDTH-1:0] z_out,
    output logic [LANES-1:0]        sat,
    output logic                    busy
);

    localparam int ACCW = acc_width(DWIDTH, DEPTH);

    // Handshake: a beat moves when in_valid && in_ready at a rising edge; a result
    // is consumed when out_valid && out_ready. Both ready/valid outputs are registered.
    state_t            state;
    state_t            state_next;
    logic [CWIDTH-1:0] remaining;
    logic [CWIDTH-1:0] n_clamped;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              load;
    logic              beat;
    logic              last;
    logic              capture;

    assign n_clamped = (n_inputs > CWIDTH'(DEPTH)) ? CWIDTH'(DEPTH) : n_inputs;
    assign beat      = in_valid && in_ready_q;
    assign last      = (remaining == CWIDTH'(1));

    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (n_clamped == '0) begin
                        capture    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = ACC;
                    end
                end
            end
            ACC: begin
                if (beat && last) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            remaining   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            in_ready_q  <= (state_next == ACC);
            out_valid_q <= (state_next == DONE);
            if (load) begin
                remaining <= n_clamped;
            end else if (beat) begin
                remaining <= remaining - CWIDTH'(1);
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = (state != IDLE);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        z_lane #(
            .DWIDTH (DWIDTH),
            .FRAC   (FRAC),
            .ACCW   (ACCW)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .load    (load),
            .beat    (beat),
            .capture (capture),
            .bias    (bias[g*DWIDTH +: DWIDTH]),
            .x       (x_in),
            .w       (w_in[g*DWIDTH +: DWIDTH]),
            .z       (z_out[g*DWIDTH +: DWIDTH]),
            .sat     (sat[g])
        );
    end

endmodule

// File: tb/tb_z_accum_array.sv
// Directed self-checking bench for z_accum_array (DWIDTH=16, FRAC=8, LANES=4, DEPTH=64).
// Expected values are hand-computed constants; Z_SAT_EN selects the saturation expectations.
module tb_z_accum_array;

    localparam int DWIDTH = 16;
    localparam int FRAC   = 8;
    localparam int LANES  = 4;
    localparam int DEPTH  = 64;
    localparam int CWIDTH = 7;
    localparam int W      = LANES * DWIDTH;

    logic              clk;
    logic              reset;
    logic              start;
    logic [CWIDTH-1:0] n_inputs;
    logic [W-1:0]      bias;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] x_in;
    logic [W-1:0]      w_in;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      z_out;
    logic [LANES-1:0]  sat;
    logic              busy;

    z_accum_array #(
        .DWIDTH (DWIDTH),
        .FRAC   (FRAC),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .CWIDTH (CWIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n_inputs  (n_inputs),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .w_in      (w_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_out     (z_out),
        .sat       (sat),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      xs_unused;
    logic [DWIDTH-1:0] xs[DEPTH];
    logic [W-1:0]      ws[DEPTH];
    int                n_checks = 0;
    int                n_pass   = 0;
    int                lat;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [DWIDTH-1:0] x, input logic [W-1:0] w);
        for (int i = 0; i < n; i++) begin
            xs[i] = x;
            ws[i] = w;
        end
    endtask

    // Start a job, feed `beats` beats, then wait (bounded) for out_valid.
    // lat = cycles from the start edge to the first cycle out_valid is seen.
    task automatic run_job(input int n, input int beats, input logic [W-1:0] b,
                           input bit gaps, input bit poke, output int cycles);
        int  k;
        bit  taken;
        start    = 1'b1;
        n_inputs = CWIDTH'(n);
        bias     = b;
        tick();
        start  = 1'b0;
        cycles = 1;
        k      = 0;
        while (k < beats && cycles < 400) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            x_in     = xs[k];
            w_in     = ws[k];
            taken    = in_valid && in_ready;
            tick();
            cycles++;
            if (taken) k++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        while (!out_valid && cycles < 400) begin
            tick();
            cycles++;
        end
    endtask

    task automatic finish_job(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_busy"}, W'(busy), W'(0));
        check({tag, "_idle_valid"}, W'(out_valid), W'(0));
    endtask

    initial begin
        xs_unused = '0;
        reset     = 1'b0;
        start     = 1'b0;
        n_inputs  = '0;
        bias      = '0;
        in_valid  = 1'b0;
        x_in      = '0;
        w_in      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_z", z_out, W'(0));
        check("rst_sat", W'(sat), W'(0));
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        @(negedge clk);
        reset = 1'b1;
        tick();

        // basic dot product: lanes w={256,-256,128,0}, bias={128,0,-1,7}
        fill(3, 16'h0100, 64'h0000_0080_FF00_0100);
        xs[1] = 16'h0200;
        xs[2] = 16'hFF00;
        exp_q.push_back(64'h0007_00FF_FE00_0280);
        run_job(3, 3, 64'h0007_FFFF_0000_0080, 1'b0, 1'b0, lat);
        check("basic_latency", W'(lat), W'(4));
        check("basic_z", z_out, exp_q.pop_front());
        check("basic_sat", W'(sat), W'(0));
        check("basic_in_ready_done", W'(in_ready), W'(0));
        finish_job("basic");

        // zero-length job: z equals bias
        exp_q.push_back(64'h7FFF_0000_FFFB_0064);
        run_job(0, 0, 64'h7FFF_0000_FFFB_0064, 1'b0, 1'b0, lat);
        check("zero_latency", W'(lat), W'(1));
        check("zero_z", z_out, exp_q.pop_front());
        finish_job("zero");

        // saturation: 2 * 32767*32767 = 2147352578, >>>8 = 8388096 = 0x7FFE00
        fill(2, 16'h7FFF, 64'h7FFF_7FFF_7FFF_7FFF);
`ifdef Z_SAT_EN
        exp_q.push_back(64'h7FFF_7FFF_7FFF_7FFF);
        run_job(2, 2, 64'h0, 1'b0, 1'b0, lat);
        check("sat_z", z_out, exp_q.pop_front());
        check("sat_flags", W'(sat), W'(4'hF));
`else
        exp_q.push_back(64'hFE00_FE00_FE00_FE00);
        run_job(2, 2, 64'h0, 1'b0, 1'b0, lat);
        check("wrap_z", z_out, exp_q.pop_front());
        check("wrap_flags", W'(sat), W'(0));
`endif
        check("sat_latency", W'(lat), W'(3));
        finish_job("sat");

        // 10-beat job, x=1.0, w={1.0,-0.5,3/256,1/256} -> z={2560,-1280,30,10}
        fill(10, 16'h0100, 64'h0001_0003_FF80_0100);
        exp_q.push_back(64'h000A_001E_FB00_0A00);
        run_job(10, 10, 64'h0, 1'b0, 1'b0, lat);
        check("nogap_latency", W'(lat), W'(11));
        check("nogap_z", z_out, exp_q.pop_front());
        finish_job("nogap");

        // same job with input gaps and start pokes in ACC and DONE
        exp_q.push_back(64'h000A_001E_FB00_0A00);
        run_job(10, 10, 64'h0, 1'b1, 1'b1, lat);
        check("gap_z", z_out, exp_q[0]);
        start    = 1'b1;
        n_inputs = CWIDTH'(0);
        bias     = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_z", z_out, exp_q[0]);
            check("hold_valid", W'(out_valid), W'(1));
        end
        void'(exp_q.pop_front());
        start = 1'b0;
        finish_job("gap");

        // n_inputs above DEPTH clamps to 64 beats: 64 * 256 = 16384 -> z lane0 = 64
        fill(DEPTH, 16'h0100, 64'h0000_0000_0000_0001);
        exp_q.push_back(64'h0000_0000_0000_0040);
        run_job(100, DEPTH, 64'h0, 1'b0, 1'b0, lat);
        check("clamp_latency", W'(lat), W'(DEPTH + 1));
        check("clamp_z", z_out, exp_q.pop_front());
        check("clamp_in_ready", W'(in_ready), W'(0));
        finish_job("clamp");

        // reset after beat 2 of a 5-beat job
        fill(5, 16'h0100, 64'h0100_0100_0100_0100);
        start    = 1'b1;
        n_inputs = CWIDTH'(5);
        bias     = 64'h0010_0010_0010_0010;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        x_in     = xs[0];
        w_in     = ws[0];
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("abort_z", z_out, W'(0));
        check("abort_sat", W'(sat), W'(0));
        check("abort_in_ready", W'(in_ready), W'(0));
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_busy", W'(busy), W'(0));
        @(negedge clk);
        reset = 1'b1;
        tick();
        exp_q.push_back(64'h0100_0100_0100_0100);
        run_job(1, 1, 64'h0, 1'b0, 1'b0, lat);
        check("fresh_latency", W'(lat), W'(2));
        check("fresh_z", z_out, exp_q.pop_front());
        finish_job("fresh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
